fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 68 ++++++
 tb/tb_fifo_wr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding a FIFO write port.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   input  logic                          fifo_afull,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data
);
   localparam int LW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state;
   logic [LW-1:0] last_gnt, g, pick, idx;
   logic [CW-1:0] beats;
   logic accept, last_beat;
   always_comb begin
      g = '0;
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) g = LW'(i);
   end
   // Scan from farthest to nearest so the nearest valid requester after last_gnt wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = LW'((int'(last_gnt) + k) % NUM_REQ);
         if (req_valid[idx]) pick = idx;
      end
   end
   assign accept    = state == BURST && req_valid[g] && !fifo_full && !(fifo_wr_en && fifo_afull);
   assign req_ready = accept ? gnt : '0;
   assign last_beat = beats == CW'(MAX_BURST - 1);
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state        <= IDLE;
         gnt          <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         beats        <= '0;
         last_gnt     <= LW'(NUM_REQ - 1);
      end else begin
         fifo_wr_en <= accept;
         if (accept) fifo_wr_data <= req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
         if (state == IDLE) begin
            if (|req_valid) begin
               gnt   <= NUM_REQ'(1) << pick;
               beats <= '0;
               state <= BURST;
            end
         end else begin
            if (accept) beats <= beats + 1'b1;
            if (!req_valid[g] || (accept && last_beat)) begin
               state    <= IDLE;
               gnt      <= '0;
               last_gnt <= g;
            end
         end
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant order, burst length, stalls and reset.
module tb_fifo_wr_arbiter;
   localparam int DW = 4, NR = 4, MB = 4;
   logic wr_clk = 1'b0, wr_rst_n = 1'b0;
   logic [NR-1:0] req_valid = '0;
   logic [NR*DW-1:0] req_data = 16'hDCBA;
   logic [NR-1:0] req_ready, gnt;
   logic fifo_full = 1'b0, fifo_afull = 1'b0, fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   int errors = 0, checks = 0;
   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .gnt(gnt), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data)
   );
   always #5 wr_clk = ~wr_clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge wr_clk);
      #1;
   endtask
   task automatic do_reset(input logic [NR-1:0] v);
      wr_rst_n = 1'b0;
      req_valid = v;
      fifo_full = 1'b0;
      fifo_afull = 1'b0;
      @(posedge wr_clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_data", fifo_wr_data, 0);
      chk("rst_ready", req_ready, 0);
      @(posedge wr_clk);
      #2 wr_rst_n = 1'b1;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
   initial begin
      do_reset(4'b0101);
      tick;
      chk("s1_gnt0", gnt, 4'b0001);
      chk("s1_wr_arb", fifo_wr_en, 0);
      chk("s1_rdy", req_ready, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("s1_wr", fifo_wr_en, 1);
         chk("s1_data", fifo_wr_data, 4'hA);
         chk("s1_gnt", gnt, i == 3 ? 0 : 1);
      end
      chk("s1_idle_rdy", req_ready, 0);
      tick;
      chk("s1_gnt2", gnt, 4'b0100);
      chk("s1_wr_idle", fifo_wr_en, 0);
      do_reset(4'b1111);
      for (int p = 0; p < 5; p++) begin
         tick;
         chk("s2_gnt", gnt, 1 << (p % 4));
         chk("s2_idle_wr", fifo_wr_en, 0);
         for (int b = 0; b < 4; b++) begin
            tick;
            chk("s2_wr", fifo_wr_en, 1);
            chk("s2_data", fifo_wr_data, 4'hA + p % 4);
         end
      end
      do_reset(4'b0010);
      tick;
      chk("s3_gnt", gnt, 4'b0010);
      tick;
      chk("s3_wr1", fifo_wr_en, 1);
      chk("s3_data1", fifo_wr_data, 4'hB);
      tick;
      chk("s3_wr2", fifo_wr_en, 1);
      chk("s3_data2", fifo_wr_data, 4'hB);
      req_valid = 4'b1101;
      #1 chk("s3_rdy_drop", req_ready, 0);
      tick;
      chk("s3_wr_end", fifo_wr_en, 0);
      chk("s3_gnt_end", gnt, 0);
      chk("s3_hold_data", fifo_wr_data, 4'hB);
      tick;
      chk("s3_next_gnt", gnt, 4'b0100);
      do_reset(4'b0001);
      tick;
      chk("s4_gnt", gnt, 4'b0001);
      tick;
      chk("s4_wr1", fifo_wr_en, 1);
      tick;
      chk("s4_wr2", fifo_wr_en, 1);
      fifo_full = 1'b1;
      #1 chk("s4_rdy_full", req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("s4_stall_wr", fifo_wr_en, 0);
         chk("s4_stall_gnt", gnt, 4'b0001);
         if (i == 2) fifo_full = 1'b0;
      end
      tick;
      chk("s4_wr3", fifo_wr_en, 1);
      chk("s4_gnt3", gnt, 4'b0001);
      tick;
      chk("s4_wr4", fifo_wr_en, 1);
      chk("s4_gnt4", gnt, 0);
      req_valid = 4'b0000;
      tick;
      chk("s4_no_wr5", fifo_wr_en, 0);
      chk("s4_idle_gnt", gnt, 0);
      do_reset(4'b0001);
      fifo_afull = 1'b1;
      tick;
      chk("s5_gnt", gnt, 4'b0001);
      chk("s5_rdy_a", req_ready, 4'b0001);
      tick;
      chk("s5_wr_a", fifo_wr_en, 1);
      chk("s5_afull_rdy", req_ready, 0);
      tick;
      chk("s5_wr_b", fifo_wr_en, 0);
      chk("s5_rdy_b", req_ready, 4'b0001);
      fifo_full = 1'b1;
      #1 chk("s5_full_rdy", req_ready, 0);
      tick;
      chk("s5_full_wr", fifo_wr_en, 0);
      chk("s5_full_gnt", gnt, 4'b0001);
      do_reset(4'b0001);
      tick;
      chk("s6_gnt", gnt, 4'b0001);
      tick;
      chk("s6_wr1", fifo_wr_en, 1);
      tick;
      chk("s6_wr2", fifo_wr_en, 1);
      #2 wr_rst_n = 1'b0;
      #1;
      chk("s6_rst_gnt", gnt, 0);
      chk("s6_rst_wr", fifo_wr_en, 0);
      chk("s6_rst_data", fifo_wr_data, 0);
      chk("s6_rst_rdy", req_ready, 0);
      @(posedge wr_clk);
      #2 wr_rst_n = 1'b1;
      tick;
      chk("s6_regnt", gnt, 4'b0001);
      chk("s6_regnt_wr", fifo_wr_en, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
